// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates an instruction-fetch port and a data port onto one shared memory port
module mem_arbiter #(
   parameter int XLEN      = 32,
   parameter int ADDR_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_readEn,
   input  logic [ADDR_SIZE-1:0] i_addr,
   input  logic                 flush,
   output logic [XLEN-1:0]      i_rdata,
   output logic                 i_readFin,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [ADDR_SIZE-1:0] d_addr,
   input  logic [XLEN-1:0]      d_wdata,
   input  logic [XLEN/8-1:0]    d_wstrb,
   output logic [XLEN-1:0]      d_rdata,
   output logic                 d_fin,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   output logic [XLEN/8-1:0]    mem_wstrb,
   input  logic [XLEN-1:0]      mem_rdata,
   input  logic                 mem_ack
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t state, state_nxt;
   logic   last_grant_d;   // 0 = fetch port granted last, 1 = data port
   logic   owner_d;        // port owning the transaction in flight
   logic   drop;
   logic   fetch_req;
   logic   grant_i, grant_d;

   assign fetch_req = i_readEn & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      mem_req   = 1'b0;
      i_readFin = 1'b0;
      d_fin     = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && fetch_req) begin
               grant_d = !last_grant_d;
               grant_i = last_grant_d;
            end else begin
               grant_d = d_req;
               grant_i = fetch_req;
            end
            if (grant_d)      state_nxt = BUSY_D;
            else if (grant_i) state_nxt = BUSY_I;
         end
         BUSY_I, BUSY_D: begin
            mem_req = 1'b1;
            if (mem_ack) state_nxt = DONE;
         end
         DONE: begin
            // a flush landing on the completion cycle still kills the fetch pulse
            i_readFin = !owner_d && !drop && !flush;
            d_fin     = owner_d;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_d <= 1'b0;
         owner_d      <= 1'b0;
         drop         <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wstrb    <= '0;
         i_rdata      <= '0;
         d_rdata      <= '0;
      end else begin
         if (grant_d) begin
            owner_d      <= 1'b1;
            last_grant_d <= 1'b1;
            mem_we       <= d_we;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            mem_wstrb    <= d_wstrb;
         end else if (grant_i) begin
            owner_d      <= 1'b0;
            last_grant_d <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= i_addr;
            mem_wstrb    <= '0;
         end

         if (state == IDLE)
            drop <= 1'b0;
         else if (flush && (state == BUSY_I || (state == DONE && !owner_d)))
            drop <= 1'b1;

         if (state == BUSY_I && mem_ack && !drop && !flush)
            i_rdata <= mem_rdata;
         if (state == BUSY_D && mem_ack)
            d_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a memory/arbitration model
module tb_mem_arbiter;

   logic        clk, rst;
   logic        i_readEn, flush, i_readFin;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_fin;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   mem_arbiter #(.XLEN(32), .ADDR_SIZE(32)) dut (
      .clk(clk), .rst(rst),
      .i_readEn(i_readEn), .i_addr(i_addr), .flush(flush),
      .i_rdata(i_rdata), .i_readFin(i_readFin),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_fin(d_fin),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit          model_last_d;
   logic [31:0] exp_i_rdata, exp_d_rdata;
   logic [31:0] mem_model [logic [31:0]];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!mem_model.exists(a)) mem_model[a] = $urandom;
      return mem_model[a];
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] cur;
      cur = model_read(a);
      for (int b = 0; b < 4; b++)
         if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
      mem_model[a] = cur;
   endtask

   // Plays the memory side of one transaction; requests are already driven at an IDLE negedge.
   task automatic serve(input bit is_d, input logic [31:0] addr, input bit we,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int delay, input int flush_at);
      logic [31:0] rd;
      bit          dropped;
      int          lat;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!mem_req && lat < 8);
      check("grant_seen", mem_req, 1);
      check("grant_latency", lat, 1);
      check("cmd_addr", mem_addr, addr);
      check("cmd_we", mem_we, we);
      check("cmd_wstrb", mem_wstrb, wstrb);
      if (we) check("cmd_wdata", mem_wdata, wdata);
      dropped = 1'b0;
      for (int k = 0; k < delay; k++) begin
         if (k == flush_at) begin
            flush = 1'b1;
            if (!is_d) dropped = 1'b1;
         end
         step();
         flush = 1'b0;
         check("hold_req", mem_req, 1);
         check("hold_addr", mem_addr, addr);
         check("hold_we", mem_we, we);
      end
      if (we) rd = $urandom;
      else    rd = model_read(addr);
      mem_rdata = rd;
      mem_ack   = 1'b1;
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (we) model_write(addr, wdata, wstrb);
      if (is_d)         exp_d_rdata = rd;
      else if (!dropped) exp_i_rdata = rd;
      model_last_d = is_d;
      check("done_mem_req", mem_req, 0);
      check("i_fin", i_readFin, !is_d && !dropped);
      check("d_fin", d_fin, is_d);
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      if (is_d) d_req = 1'b0;
      else      i_readEn = 1'b0;
      step();
      check("post_i_fin", i_readFin, 0);
      check("post_d_fin", d_fin, 0);
      check("post_mem_req", mem_req, 0);
   endtask

   task automatic model_reset();
      model_last_d = 1'b0;
      exp_i_rdata  = '0;
      exp_d_rdata  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b0; i_readEn = 1'b0; i_addr = '0; flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      model_reset();
      step(); step();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_i_fin", i_readFin, 0);
      check("rst_d_fin", d_fin, 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst = 1'b1;
      step();

      // plain fetch
      mem_model[32'h100] = 32'h0000_0013;
      i_readEn = 1'b1; i_addr = 32'h100;
      serve(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 0, -1);
      check("fetch_word", i_rdata, 32'h0000_0013);

      // fetch held off while flush is high in IDLE
      i_readEn = 1'b1; i_addr = 32'h104; flush = 1'b1;
      step();
      check("flush_gate_a", mem_req, 0);
      step();
      check("flush_gate_b", mem_req, 0);
      flush = 1'b0;
      serve(1'b0, 32'h104, 1'b0, 32'h0, 4'h0, 1, -1);

      // ties after reset: data first, then alternation
      i_readEn = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wstrb = 4'hF;
      serve(1'b1, 32'h200, 1'b0, 32'h0, 4'hF, 0, -1);
      serve(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 0, -1);
      i_readEn = 1'b1; i_addr = 32'h108;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; d_wstrb = 4'h3;
      serve(1'b1, 32'h204, 1'b0, 32'h0, 4'h3, 1, -1);
      serve(1'b0, 32'h108, 1'b0, 32'h0, 4'h0, 0, -1);

      // store
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
      serve(1'b1, 32'h300, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, -1);

      // flushed fetch, then a normal one
      i_readEn = 1'b1; i_addr = 32'h180;
      serve(1'b0, 32'h180, 1'b0, 32'h0, 4'h0, 3, 0);
      i_readEn = 1'b1; i_addr = 32'h184;
      serve(1'b0, 32'h184, 1'b0, 32'h0, 4'h0, 0, -1);

      // slow memory, with a flush that must not touch the data port
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wstrb = 4'h1;
      serve(1'b1, 32'h300, 1'b0, 32'h0, 4'h1, 5, 2);
      check("store_readback", d_rdata, 32'hDEAD_BEEF);

      // reset in the middle of a data transaction
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h040; d_wstrb = 4'hF;
      n = 0;
      do begin
         step();
         n++;
      end while (!mem_req && n < 8);
      check("rst_op_grant", mem_req, 1);
      #2 rst = 1'b0;
      #1;
      check("rst_op_mem_req", mem_req, 0);
      check("rst_op_mem_we", mem_we, 0);
      check("rst_op_d_fin", d_fin, 0);
      check("rst_op_mem_addr", mem_addr, 0);
      d_req = 1'b0;
      model_reset();
      step();
      rst = 1'b1;
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_ack = 1'b0;
      check("late_ack_mem_req", mem_req, 0);
      check("late_ack_d_fin", d_fin, 0);
      check("late_ack_d_rdata", d_rdata, 0);
      step();
      check("late_ack_d_fin2", d_fin, 0);
      i_readEn = 1'b1; i_addr = 32'h10C;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20C; d_wstrb = 4'hF;
      serve(1'b1, 32'h20C, 1'b0, 32'h0, 4'hF, 0, -1);
      serve(1'b0, 32'h10C, 1'b0, 32'h0, 4'h0, 0, -1);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         int          pat, dly, fl;
         logic [31:0] ia, da, dwd;
         logic [3:0]  dws;
         bit          dwe, first_d;
         pat = $urandom_range(0, 2);
         ia  = $urandom_range(0, 15) * 4;
         da  = $urandom_range(0, 15) * 4;
         dwe = 1'($urandom_range(0, 1));
         dwd = $urandom;
         dws = 4'($urandom_range(1, 15));
         dly = $urandom_range(0, 5);
         fl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
         if (pat != 1) begin
            i_readEn = 1'b1; i_addr = ia;
         end
         if (pat != 0) begin
            d_req = 1'b1; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dws;
         end
         if (pat == 0) begin
            serve(1'b0, ia, 1'b0, 32'h0, 4'h0, dly, fl);
         end else if (pat == 1) begin
            serve(1'b1, da, dwe, dwd, dws, dly, fl);
         end else begin
            first_d = !model_last_d;
            if (first_d) begin
               serve(1'b1, da, dwe, dwd, dws, dly, -1);
               serve(1'b0, ia, 1'b0, 32'h0, 4'h0, $urandom_range(0, 3), -1);
            end else begin
               serve(1'b0, ia, 1'b0, 32'h0, 4'h0, dly, -1);
               serve(1'b1, da, dwe, dwd, dws, $urandom_range(0, 3), -1);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
